// File: rtl/agc_timing_pkg.sv
// Shared timing definitions for the AGC control-section timer and its monitor:
// FSM state encoding, error codes and time-pulse indices.
package agc_timing_pkg;

  localparam int TP_W = 12;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SYNC  = 2'd1;
  localparam logic [1:0] ST_TRACK = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_SEQ   = 2'd1;
  localparam logic [1:0] ERR_MULTI = 2'd2;
  localparam logic [1:0] ERR_STALL = 2'd3;

  localparam logic [3:0] T01_IDX = 4'd0;
  localparam logic [3:0] T02_IDX = 4'd1;
  localparam logic [3:0] T03_IDX = 4'd2;
  localparam logic [3:0] T04_IDX = 4'd3;
  localparam logic [3:0] T05_IDX = 4'd4;
  localparam logic [3:0] T06_IDX = 4'd5;
  localparam logic [3:0] T07_IDX = 4'd6;
  localparam logic [3:0] T08_IDX = 4'd7;
  localparam logic [3:0] T09_IDX = 4'd8;
  localparam logic [3:0] T10_IDX = 4'd9;
  localparam logic [3:0] T11_IDX = 4'd10;
  localparam logic [3:0] T12_IDX = 4'd11;

  // Successor pulse in the T01..T12 ring.
  function automatic logic [3:0] next_tidx(input logic [3:0] i);
    return (i == T12_IDX) ? T01_IDX : i + 4'd1;
  endfunction

endpackage

// File: rtl/tpulse_encode.sv
// Combinational classifier for the one-hot time-pulse bus: lowest set index,
// plus exactly-one / more-than-one / none flags.
module tpulse_encode
  import agc_timing_pkg::*;
(
  input  logic [TP_W-1:0] tp,
  output logic [3:0]      idx,
  output logic            valid,
  output logic            multi,
  output logic            zero
);

  logic [3:0] ones;

  always_comb begin
    idx  = '0;
    ones = '0;
    for (int i = TP_W - 1; i >= 0; i--) begin
      if (tp[i]) idx = 4'(i);
      ones = ones + {3'b000, tp[i]};
    end
    valid = (ones == 4'd1);
    multi = (ones > 4'd1);
    zero  = (ones == 4'd0);
  end

endmodule

// File: rtl/tpulse_monitor.sv
// Watches the timer's T01..T12 pulse sequence, flags sequence/overlap/stall
// faults, counts memory cycles and requests a GOJ1 restart on a fault.
module tpulse_monitor
  import agc_timing_pkg::*;
#(
  parameter int STALL_MAX = 32,
  parameter int GAP_MAX   = 4,
  parameter int GOJ_WIDTH = 4
) (
  input  logic        CLOCK,
  input  logic        SIM_RST_n,
  input  logic [11:0] TPULSE,
  input  logic        GOJAM,
  input  logic        STOP,
  input  logic        TERR_CLR,
  output logic        IN_SYNC,
  output logic [15:0] MCT_CNT,
  output logic        TERR,
  output logic [1:0]  ERR_CODE,
  output logic        GOJ1_REQ
);

  localparam int CNT_MAX = ((STALL_MAX > GAP_MAX) ? STALL_MAX : GAP_MAX) + 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int GOJ_W   = $clog2(GOJ_WIDTH + 1);

  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(STALL_MAX - 1);
  localparam logic [CNT_W-1:0] GAP_LIM   = CNT_W'(GAP_MAX - 1);
  localparam logic [GOJ_W-1:0] GOJ_END   = GOJ_W'(GOJ_WIDTH);

  // Symbols beyond T12 so "no pulse" and "overlap" runs are counted apart from real pulses.
  localparam logic [3:0] SYM_ZERO  = 4'd12;
  localparam logic [3:0] SYM_MULTI = 4'd13;

  logic [11:0]      tp_q;
  logic [3:0]       idx;
  logic             valid;
  logic             multi;
  logic             zero;

  logic [1:0]       state;
  logic [3:0]       expected;
  logic [3:0]       prev_idx;
  logic [3:0]       last_sym;
  logic [3:0]       sym;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_nxt;
  logic [GOJ_W-1:0] goj_cnt;
  logic             same;
  logic             hold_err;
  logic             restart;
  logic             err_now;
  logic [1:0]       err_sel;

  tpulse_encode u_encode (
    .tp    (tp_q),
    .idx   (idx),
    .valid (valid),
    .multi (multi),
    .zero  (zero)
  );

  always_comb begin
    sym      = zero ? SYM_ZERO : (multi ? SYM_MULTI : idx);
    same     = (sym == last_sym);
    hold_nxt = '0;
    if (same) hold_nxt = (hold_cnt == CNT_SAT) ? hold_cnt : hold_cnt + CNT_W'(1);
    // hold_cnt is one less than the run length, so these fire on run = limit + 1.
    hold_err = same && ((valid && hold_cnt >= STALL_LIM) || (zero && hold_cnt >= GAP_LIM));
    err_sel  = ERR_NONE;
    if (multi)                                              err_sel = ERR_MULTI;
    else if (valid && idx != prev_idx && idx != expected)   err_sel = ERR_SEQ;
    else if (hold_err)                                      err_sel = ERR_STALL;
    restart  = GOJAM | STOP;
    err_now  = (state == ST_TRACK) && !restart && (err_sel != ERR_NONE);
  end

  always_ff @(posedge CLOCK or negedge SIM_RST_n) begin
    if (!SIM_RST_n) begin
      tp_q     <= '0;
      state    <= ST_IDLE;
      expected <= T02_IDX;
      prev_idx <= T01_IDX;
      last_sym <= SYM_ZERO;
      hold_cnt <= '0;
      goj_cnt  <= '0;
      IN_SYNC  <= 1'b0;
      MCT_CNT  <= '0;
      TERR     <= 1'b0;
      ERR_CODE <= ERR_NONE;
      GOJ1_REQ <= 1'b0;
    end else begin
      // Stage 0: register the pulse bus
      tp_q     <= TPULSE;
      // Stage 1: sequence tracking on the registered pulses
      last_sym <= sym;
      hold_cnt <= hold_nxt;
      if (restart) begin
        state    <= ST_IDLE;
        IN_SYNC  <= 1'b0;
        GOJ1_REQ <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: state <= ST_SYNC;
          ST_SYNC: begin
            if (valid && idx == T01_IDX) begin
              state    <= ST_TRACK;
              IN_SYNC  <= 1'b1;
              prev_idx <= T01_IDX;
              expected <= next_tidx(T01_IDX);
              hold_cnt <= '0;
            end
          end
          ST_TRACK: begin
            if (err_now) begin
              state    <= ST_FAULT;
              IN_SYNC  <= 1'b0;
              GOJ1_REQ <= 1'b1;
              goj_cnt  <= GOJ_W'(1);
            end else if (valid && idx != prev_idx) begin
              prev_idx <= idx;
              expected <= next_tidx(idx);
              if (prev_idx == T12_IDX && idx == T01_IDX) MCT_CNT <= MCT_CNT + 16'd1;
            end
          end
          ST_FAULT: begin
            if (goj_cnt == GOJ_END) begin
              state    <= ST_SYNC;
              GOJ1_REQ <= 1'b0;
            end else begin
              goj_cnt <= goj_cnt + GOJ_W'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
      // A fault in the same cycle as a clear wins and records its own code.
      if (err_now) begin
        TERR <= 1'b1;
        if (!TERR || TERR_CLR) ERR_CODE <= err_sel;
      end else if (TERR_CLR) begin
        TERR     <= 1'b0;
        ERR_CODE <= ERR_NONE;
      end
    end
  end

endmodule

// File: tb/tb_tpulse_monitor.sv
// Bench for tpulse_monitor: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a behavioural model.
module tb_tpulse_monitor;

  localparam int STALL_MAX = 32;
  localparam int GAP_MAX   = 4;
  localparam int GOJ_WIDTH = 4;

  logic        CLOCK     = 1'b0;
  logic        SIM_RST_n = 1'b0;
  logic [11:0] TPULSE    = '0;
  logic        GOJAM     = 1'b0;
  logic        STOP      = 1'b0;
  logic        TERR_CLR  = 1'b0;
  logic        IN_SYNC;
  logic [15:0] MCT_CNT;
  logic        TERR;
  logic [1:0]  ERR_CODE;
  logic        GOJ1_REQ;

  int n_chk  = 0;
  int n_pass = 0;
  int goj_hi = 0;
  bit chk_en = 1'b0;

  tpulse_monitor #(
    .STALL_MAX (STALL_MAX),
    .GAP_MAX   (GAP_MAX),
    .GOJ_WIDTH (GOJ_WIDTH)
  ) dut (
    .CLOCK     (CLOCK),
    .SIM_RST_n (SIM_RST_n),
    .TPULSE    (TPULSE),
    .GOJAM     (GOJAM),
    .STOP      (STOP),
    .TERR_CLR  (TERR_CLR),
    .IN_SYNC   (IN_SYNC),
    .MCT_CNT   (MCT_CNT),
    .TERR      (TERR),
    .ERR_CODE  (ERR_CODE),
    .GOJ1_REQ  (GOJ1_REQ)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic int pos_of(input logic [11:0] v);
    for (int i = 0; i < 12; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Behavioural model: mode 0 idle, 1 waiting for T01, 2 tracking, 3 restart request.
  int          m_mode     = 0;
  int          m_prev     = 0;
  int          m_run      = 0;
  int          m_mct      = 0;
  int          m_code     = 0;
  int          m_goj_rem  = 0;
  bit          m_terr     = 1'b0;
  bit          m_goj      = 1'b0;
  logic [11:0] m_last_obs = '0;
  logic [11:0] m_prev_tp  = '0;

  task automatic model_step();
    logic [11:0] obs;
    int n, p, e;
    if (!SIM_RST_n) begin
      m_mode = 0; m_prev = 0; m_run = 0; m_mct = 0; m_code = 0; m_goj_rem = 0;
      m_terr = 1'b0; m_goj = 1'b0; m_last_obs = '0; m_prev_tp = '0;
      return;
    end
    obs = m_prev_tp;
    n   = $countones(obs);
    p   = pos_of(obs);
    if (obs == m_last_obs) m_run++; else m_run = 1;
    m_last_obs = obs;
    e = 0;
    if (GOJAM || STOP) begin
      m_mode = 0;
      m_goj  = 1'b0;
    end else begin
      case (m_mode)
        0: m_mode = 1;
        1: if (obs == 12'h001) begin m_mode = 2; m_prev = 0; m_run = 1; end
        2: begin
          if (n > 1) e = 2;
          else if (n == 1 && p != m_prev && p != (m_prev + 1) % 12) e = 1;
          else if ((n == 1 && m_run > STALL_MAX) || (n == 0 && m_run > GAP_MAX)) e = 3;
          if (e != 0) begin
            m_mode = 3; m_goj = 1'b1; m_goj_rem = GOJ_WIDTH - 1;
          end else if (n == 1 && p != m_prev) begin
            if (m_prev == 11 && p == 0) m_mct = (m_mct + 1) % 65536;
            m_prev = p;
          end
        end
        default: if (m_goj_rem == 0) begin m_mode = 1; m_goj = 1'b0; end else m_goj_rem--;
      endcase
    end
    if (e != 0) begin
      if (!m_terr || TERR_CLR) m_code = e;
      m_terr = 1'b1;
    end else if (TERR_CLR) begin
      m_terr = 1'b0; m_code = 0;
    end
    m_prev_tp = TPULSE;
  endtask

  initial forever begin
    @(posedge CLOCK or negedge SIM_RST_n);
    model_step();
  end

  initial forever begin
    @(negedge CLOCK);
    if (chk_en) begin
      check("in_sync",  IN_SYNC,  (m_mode == 2) ? 1 : 0);
      check("mct_cnt",  MCT_CNT,  m_mct);
      check("terr",     TERR,     m_terr);
      check("err_code", ERR_CODE, m_code);
      check("goj1_req", GOJ1_REQ, m_goj);
      if (GOJ1_REQ) goj_hi++;
    end
  end

  task automatic cyc(input logic [11:0] tp);
    @(negedge CLOCK);
    #1;
    TPULSE = tp;
  endtask

  task automatic hold(input int k, input int d);
    logic [11:0] v;
    v = 12'h001 << k;
    repeat (d) cyc(v);
  endtask

  task automatic hold_span(input int k0, input int k1, input int d);
    for (int k = k0; k <= k1; k++) hold(k, d);
  endtask

  task automatic clear_err();
    TERR_CLR = 1'b1;
    cyc(12'h000);
    TERR_CLR = 1'b0;
    cyc(12'h000);
  endtask

  int          g0;
  int          k;
  int          r;
  int          d;
  logic [11:0] v;

  initial begin
    repeat (3) @(negedge CLOCK);
    #1;
    check("rst_in_sync",  IN_SYNC,  0);
    check("rst_mct",      MCT_CNT,  0);
    check("rst_terr",     TERR,     0);
    check("rst_err_code", ERR_CODE, 0);
    check("rst_goj",      GOJ1_REQ, 0);
    chk_en    = 1'b1;
    SIM_RST_n = 1'b1;
    repeat (3) cyc(12'h000);

    // Clean run: three full MCTs then T01.
    g0 = goj_hi;
    cyc(12'h001);
    cyc(12'h001);
    check("t1_in_sync_edge1", IN_SYNC, 0);
    cyc(12'h001);
    check("t1_in_sync_edge2", IN_SYNC, 1);
    cyc(12'h001);
    hold_span(1, 11, 4);
    hold_span(0, 11, 4);
    hold_span(0, 11, 4);
    hold(0, 4);
    check("t1_mct",  MCT_CNT, 3);
    check("t1_terr", TERR, 0);
    check("t1_goj_cycles", goj_hi - g0, 0);

    // Skipped pulse: T04 then T06.
    hold_span(1, 3, 4);
    g0 = goj_hi;
    hold(5, 12);
    check("t2_err_code", ERR_CODE, 1);
    check("t2_terr", TERR, 1);
    check("t2_goj_cycles", goj_hi - g0, 4);
    check("t2_in_sync", IN_SYNC, 0);
    clear_err();
    check("clr_terr", TERR, 0);
    check("clr_err_code", ERR_CODE, 0);

    // Overlap: T03 and T04 together.
    hold_span(0, 1, 4);
    cyc(12'h00C);
    repeat (6) cyc(12'h000);
    check("t3_err_code", ERR_CODE, 2);

    // Clear in the same cycle as a SEQ error while code 2 is held.
    hold_span(0, 1, 4);
    cyc(12'h008);
    cyc(12'h008);
    TERR_CLR = 1'b1;
    cyc(12'h008);
    TERR_CLR = 1'b0;
    cyc(12'h000);
    check("t6_terr", TERR, 1);
    check("t6_err_code", ERR_CODE, 1);
    repeat (6) cyc(12'h000);
    clear_err();

    // Stall: 32 clocks legal, 33 faults.
    hold_span(0, 5, 4);
    hold(6, 32);
    hold(7, 4);
    check("t4_hold32_terr", TERR, 0);
    hold_span(8, 11, 4);
    hold_span(0, 5, 4);
    hold(6, 33);
    cyc(12'h080);
    check("t4_hold33_before", ERR_CODE, 0);
    cyc(12'h080);
    check("t4_hold33_code", ERR_CODE, 3);
    repeat (6) cyc(12'h000);
    clear_err();

    // Restart via GOJAM at T05.
    hold_span(0, 3, 4);
    cyc(12'h010);
    check("t5_mct_before", MCT_CNT, 4);
    GOJAM = 1'b1;
    repeat (3) cyc(12'h010);
    check("t5_in_sync", IN_SYNC, 0);
    check("t5_terr", TERR, 0);
    check("t5_goj", GOJ1_REQ, 0);
    GOJAM = 1'b0;
    repeat (2) cyc(12'h000);
    hold(0, 4);
    check("t5_resync", IN_SYNC, 1);
    check("t5_mct_after", MCT_CNT, 4);
    hold(1, 4);

    // Randomized run.
    k = 2;
    for (int it = 0; it < 500; it++) begin
      r = $urandom_range(0, 99);
      d = $urandom_range(1, 6);
      v = 12'h001 << k;
      if (r < 4)       d = $urandom_range(29, 34);
      else if (r < 8)  v = 12'h001 << $urandom_range(0, 11);
      else if (r < 11) v = v | (12'h001 << $urandom_range(0, 11));
      else if (r < 16) v = '0;
      if (r >= 16 && r < 19) GOJAM = 1'b1;
      else if (r == 19)      STOP  = 1'b1;
      if (r >= 20 && r < 24) TERR_CLR = 1'b1;
      repeat (d) begin
        cyc(v);
        TERR_CLR = 1'b0;
      end
      GOJAM = 1'b0;
      STOP  = 1'b0;
      if (r == 99 && it > 50) begin
        SIM_RST_n = 1'b0;
        cyc(12'h000);
        cyc(12'h000);
        SIM_RST_n = 1'b1;
      end
      if ($countones(v) == 1) k = (pos_of(v) + 1) % 12;
    end
    repeat (4) cyc(12'h000);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
